// File: rtl/pll_rst_pkg.sv
// Shared types and default constants for the PLL reset sequencer.
// Optional lock-timeout feature is controlled by RSTSEQ_LOCK_TIMEOUT_EN in the top module.
package pll_rst_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } rstseq_state_t;

    localparam int DEF_NUM_DOMAINS    = 4;
    localparam int DEF_PLL_RST_CYCLES = 16;
    localparam int DEF_STABLE_CYCLES  = 1024;
    localparam int DEF_STAGE_GAP      = 8;
    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_LOCK_TIMEOUT   = 65536;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // The counter runs 0..N-1 for every phase, so log2 of the largest span is enough.
    function automatic int cnt_width(input int num_domains, input int pll_rst_cycles,
                                     input int stable_cycles, input int stage_gap,
                                     input int lock_timeout);
        int m;
        m = max2(pll_rst_cycles, stable_cycles);
        m = max2(m, (num_domains - 1) * stage_gap + 1);
        m = max2(m, lock_timeout);
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_NUM_DOMAINS, DEF_PLL_RST_CYCLES,
                                         DEF_STABLE_CYCLES, DEF_STAGE_GAP,
                                         DEF_LOCK_TIMEOUT);

endpackage

// File: rtl/pll_reset_sequencer_bit_sync.sv
// Single-bit multi-flop synchronizer with synchronous active-low clear.
module bit_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic clr_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, qualifies lock, then releases domain resets in order.
// Define RSTSEQ_LOCK_TIMEOUT_EN to re-pulse the PLL reset when lock does not arrive in time.
//
// state        | meaning
// ST_PLL_RST   | pll_rst held high for PLL_RST_CYCLES
// ST_WAIT_LOCK | waiting for synchronized lock
// ST_STABLE    | counting consecutive locked cycles
// ST_RELEASE   | releasing domain resets one by one
// ST_RUN       | all domains released, seq_ready high
module pll_reset_sequencer
    import pll_rst_pkg::*;
#(
    parameter int NUM_DOMAINS    = DEF_NUM_DOMAINS,
    parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int STAGE_GAP      = DEF_STAGE_GAP,
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pll_locked,
    input  logic                   sw_rst_req,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] domain_rst_n,
    output logic                   seq_ready,
    output logic [7:0]             relock_count
);

    localparam int CNT_W = cnt_width(NUM_DOMAINS, PLL_RST_CYCLES, STABLE_CYCLES,
                                     STAGE_GAP, LOCK_TIMEOUT);

    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'((NUM_DOMAINS - 1) * STAGE_GAP);
`ifdef RSTSEQ_LOCK_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
`endif

    logic                   lock_s;
    rstseq_state_t          state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   pll_rst_q, pll_rst_d;
    logic [NUM_DOMAINS-1:0] dom_q, dom_d;
    logic                   ready_q, ready_d;
    logic [7:0]             relock_q, relock_d;

    bit_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk),
        .clr_n (rst_n),
        .d     (pll_locked),
        .q     (lock_s)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_PLL_RST;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            dom_q     <= '0;
            ready_q   <= 1'b0;
            relock_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pll_rst_q <= pll_rst_d;
            dom_q     <= dom_d;
            ready_q   <= ready_d;
            relock_q  <= relock_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        dom_d     = dom_q;
        relock_d  = relock_q;
        ready_d   = 1'b0;
        pll_rst_d = 1'b0;

        case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == PLL_RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end
`ifdef RSTSEQ_LOCK_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_PLL_RST;
                    cnt_d   = '0;
                end
`else
                else begin
                    cnt_d = '0;
                end
`endif
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end
            end
            ST_RELEASE: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    for (int i = 0; i < NUM_DOMAINS; i++) begin
                        if (cnt_q == CNT_W'(i * STAGE_GAP)) dom_d[i] = 1'b1;
                    end
                    if (cnt_q == RELEASE_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_PLL_RST;
                cnt_d   = '0;
            end
        endcase

        // Software request overrides everything, including a coincident lock loss.
        if (sw_rst_req) begin
            state_d  = ST_PLL_RST;
            cnt_d    = '0;
            relock_d = relock_q;
        end

        if (state_d == ST_PLL_RST || state_d == ST_WAIT_LOCK) dom_d = '0;
        ready_d   = (state_q == ST_RUN) && (state_d == ST_RUN);
        pll_rst_d = (state_d == ST_PLL_RST);
    end

    assign pll_rst      = pll_rst_q;
    assign domain_rst_n = dom_q;
    assign seq_ready    = ready_q;
    assign relock_count = relock_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed testbench for pll_reset_sequencer; expectations are hand-computed cycle positions.
module tb_pll_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       sw_rst_req;
    logic       pll_rst;
    logic [3:0] domain_rst_n;
    logic       seq_ready;
    logic [7:0] relock_count;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

`ifdef RSTSEQ_LOCK_TIMEOUT_EN
    localparam logic TO_EN = 1'b1;
`else
    localparam logic TO_EN = 1'b0;
`endif

    pll_reset_sequencer #(
        .NUM_DOMAINS    (4),
        .PLL_RST_CYCLES (4),
        .STABLE_CYCLES  (10),
        .STAGE_GAP      (3),
        .SYNC_STAGES    (2),
        .LOCK_TIMEOUT   (20)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .sw_rst_req   (sw_rst_req),
        .pll_rst      (pll_rst),
        .domain_rst_n (domain_rst_n),
        .seq_ready    (seq_ready),
        .relock_count (relock_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        sw_rst_req = 1'b0;

        // Reset values, then lock held low: timeout behaviour
        repeat (3) step();
        chk("rst_pll_rst", pll_rst, 1);
        chk("rst_domain", domain_rst_n, 4'b0000);
        chk("rst_ready", seq_ready, 0);
        chk("rst_relock", relock_count, 0);
        rst_n = 1'b1;
        cyc   = -1;
        step_to(2);  chk("to_pulse1_hi", pll_rst, 1);
        step_to(3);  chk("to_pulse1_lo", pll_rst, 0);
        step_to(22); chk("to_wait_end", pll_rst, 0);
        step_to(23); chk("to_pulse2_start", pll_rst, TO_EN);
        step_to(26); chk("to_pulse2_last", pll_rst, TO_EN);
        step_to(27); chk("to_pulse2_end", pll_rst, 0);
        step_to(47); chk("to_pulse3_start", pll_rst, TO_EN);
        chk("to_domain", domain_rst_n, 4'b0000);

        // Cold start with lock held high
        rst_n      = 1'b0;
        pll_locked = 1'b1;
        repeat (2) step();
        rst_n = 1'b1;
        cyc   = -1;
        step_to(0);  chk("cold_pll_rst_e0", pll_rst, 1);
        step_to(2);  chk("cold_pll_rst_e2", pll_rst, 1);
        step_to(3);  chk("cold_pll_rst_e3", pll_rst, 0);
        step_to(14); chk("cold_dom_e14", domain_rst_n, 4'b0000);
        step_to(15); chk("cold_dom_e15", domain_rst_n, 4'b0001);
        step_to(17); chk("cold_dom_e17", domain_rst_n, 4'b0001);
        step_to(18); chk("cold_dom_e18", domain_rst_n, 4'b0011);
        step_to(20); chk("cold_dom_e20", domain_rst_n, 4'b0011);
        step_to(21); chk("cold_dom_e21", domain_rst_n, 4'b0111);
        step_to(23); chk("cold_dom_e23", domain_rst_n, 4'b0111);
        step_to(24); chk("cold_dom_e24", domain_rst_n, 4'b1111);
        chk("cold_ready_e24", seq_ready, 0);
        step_to(25); chk("cold_ready_e25", seq_ready, 1);
        chk("cold_relock", relock_count, 0);

        // Lock loss in RUN
        step_to(27);
        pll_locked = 1'b0;
        cyc        = -1;
        step_to(1);
        chk("loss_dom_e1", domain_rst_n, 4'b1111);
        chk("loss_ready_e1", seq_ready, 1);
        step_to(2);
        chk("loss_dom_e2", domain_rst_n, 4'b0000);
        chk("loss_ready_e2", seq_ready, 0);
        chk("loss_relock", relock_count, 1);

        // Re-lock with a one-cycle glitch at stable count 6
        step_to(4);
        pll_locked = 1'b1;
        cyc        = -1;
        step_to(8);
        pll_locked = 1'b0;
        step_to(9);
        pll_locked = 1'b1;
        step_to(13); chk("glitch_dom_e13", domain_rst_n, 4'b0000);
        step_to(22); chk("glitch_dom_e22", domain_rst_n, 4'b0000);
        step_to(23); chk("glitch_dom_e23", domain_rst_n, 4'b0001);
        step_to(32); chk("glitch_dom_e32", domain_rst_n, 4'b1111);
        step_to(33);
        chk("glitch_ready", seq_ready, 1);
        chk("glitch_relock", relock_count, 1);

        // Software request coincident with lock loss in RUN
        step_to(35);
        pll_locked = 1'b0;
        cyc        = -1;
        step_to(1);
        chk("sw_pll_rst_e1", pll_rst, 0);
        sw_rst_req = 1'b1;
        step_to(2);
        sw_rst_req = 1'b0;
        chk("sw_pll_rst_e2", pll_rst, 1);
        chk("sw_dom_e2", domain_rst_n, 4'b0000);
        chk("sw_ready_e2", seq_ready, 0);
        chk("sw_relock", relock_count, 1);
        step_to(5);  chk("sw_pll_rst_e5", pll_rst, 1);
        step_to(6);  chk("sw_pll_rst_e6", pll_rst, 0);
        chk("sw_relock_after", relock_count, 1);

        // rst_n during RELEASE after domain 1 released
        step_to(7);
        pll_locked = 1'b1;
        cyc        = -1;
        step_to(16); chk("mid_dom_e16", domain_rst_n, 4'b0011);
        rst_n = 1'b0;
        step_to(17);
        chk("mid_pll_rst", pll_rst, 1);
        chk("mid_dom", domain_rst_n, 4'b0000);
        chk("mid_ready", seq_ready, 0);
        chk("mid_relock", relock_count, 0);
        rst_n = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Reset sequencer that consumes the PLL `locked` indication and drives the PLL `rst` input. It releases per-domain resets in a fixed staggered order, one domain per PLL output clock. It runs in the 50 MHz system clock domain (PLL output 0) and sits directly downstream of the PLL wrapper. The per-domain reset outputs feed the reset synchronizers of each clock domain.

## Interface
- `NUM_DOMAINS`, 4: number of staged reset outputs; index 0 is released first.
- `PLL_RST_CYCLES`, 16: length of the `pll_rst` pulse, in clk cycles.
- `STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required before any domain is released.
- `STAGE_GAP`, 8: clk cycles between consecutive domain releases; must be ≥1.
- `SYNC_STAGES`, 2: flops in the `pll_locked` synchronizer; must be ≥2.
- `LOCK_TIMEOUT`, 65536: cycles allowed in WAIT_LOCK before the PLL is reset again; only used with the timeout feature.
- `clk`, in, 1: system clock. One clock.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `pll_locked`, in, 1: PLL lock, asynchronous to `clk`.
- `sw_rst_req`, in, 1: single-cycle software request for a full re-sequence.
- `pll_rst`, out, 1: active-high reset to the PLL.
- `domain_rst_n`, out, NUM_DOMAINS: active-low per-domain resets.
- `seq_ready`, out, 1: high once all domains are released.
- `relock_count`, out, 8: count of lock losses seen in RUN; saturates at 255.

## Operation
- The `pll_locked` input passes through the synchronizer to give `lock_s`. All decisions use `lock_s`.
- FSM states: PLL_RST, WAIT_LOCK, STABLE, RELEASE, RUN.
- PLL_RST: `pll_rst`=1 for exactly PLL_RST_CYCLES cycles, then go to WAIT_LOCK.
- WAIT_LOCK: `pll_rst`=0. When `lock_s`=1, go to STABLE with the counter cleared.
- STABLE: count consecutive cycles with `lock_s`=1.
  - If `lock_s`=0, go back to WAIT_LOCK.
  - When the count reaches STABLE_CYCLES, go to RELEASE.
- RELEASE: on RELEASE cycle k (k=0 is the first), deassert `domain_rst_n[i]` when k == i*STAGE_GAP. Released domains stay released. Enter RUN the cycle after the last domain is released.
- RUN: `seq_ready`=1.
- Lock loss: `lock_s`=0 in STABLE, RELEASE or RUN sends the FSM to WAIT_LOCK.
  - All `domain_rst_n` are asserted and `seq_ready` is cleared.
  - `relock_count` increments, saturating, only when the loss occurs in RUN.
- `sw_rst_req`=1 in any state sends the FSM to PLL_RST, asserts all domain resets and clears `seq_ready`. In PLL_RST it restarts the pulse counter.
- Simultaneous `sw_rst_req` and lock loss: `sw_rst_req` wins and `relock_count` does not increment.

## Timing
- Reset values: `pll_rst`=1, `domain_rst_n`=all 0, `seq_ready`=0, `relock_count`=0. State is PLL_RST with the counter at 0, and the synchronizer is cleared to 0.
- `rst_n` asserted mid-sequence returns the block to reset values on the next edge.
- All outputs are registered. An output change appears on the clk edge after the state transition that causes it.
- A `pll_locked` rise becomes visible in `lock_s` after SYNC_STAGES edges.
- Release of domain 0 follows the edge that ends STABLE by one cycle.
- Release of domain i follows release of domain 0 by i*STAGE_GAP cycles.
- `seq_ready` rises one cycle after the last release.
- Lock loss to all resets asserted: SYNC_STAGES+1 cycles from the `pll_locked` fall.
- Assertion of `domain_rst_n` is simultaneous across all domains. Release is strictly ordered by index.

## Configuration
- `RSTSEQ_LOCK_TIMEOUT_EN` defined:
  - WAIT_LOCK counts cycles.
  - If the count reaches LOCK_TIMEOUT without `lock_s`=1, go to PLL_RST (a new PLL reset pulse).
  - Entering STABLE clears the count.
- Not defined: WAIT_LOCK waits indefinitely, the timeout counter is absent, and LOCK_TIMEOUT is ignored.

## Structure
- Package `pll_rst_pkg`:
  - FSM state enum `rstseq_state_t`.
  - Default parameter constants.
  - Width helper constant for the shared cycle counter, sized to max(PLL_RST_CYCLES, STABLE_CYCLES, (NUM_DOMAINS-1)*STAGE_GAP+1, LOCK_TIMEOUT).
- One sub-module, `bit_sync`: a parameterised SYNC_STAGES-deep single-bit synchronizer with a synchronous active-low clear.
- FSM, counters and output registers live in the top module.

## Test plan
Bench parameters for all scenarios: PLL_RST_CYCLES=4, STABLE_CYCLES=10, STAGE_GAP=3, SYNC_STAGES=2, NUM_DOMAINS=4.
- Cold start with `pll_locked` held 1:
  - `pll_rst`=1 for 4 cycles after `rst_n` rises.
  - Domains 0..3 release 3 cycles apart.
  - `seq_ready`=1 one cycle after domain 3 releases.
- Lock glitch in STABLE: `pll_locked` low for 1 cycle at stable count 6 → count restarts; no domain released before 10 fresh lock cycles.
- Lock loss in RUN:
  - `pll_locked` falls → all `domain_rst_n`=0 and `seq_ready`=0 exactly 3 cycles later.
  - `relock_count` goes 0→1.
  - Re-lock re-runs STABLE and RELEASE.
- `sw_rst_req` in the same cycle as a lock loss in RUN → PLL_RST entered, `pll_rst` pulse of 4 cycles, `relock_count` unchanged.
- With `RSTSEQ_LOCK_TIMEOUT_EN` and LOCK_TIMEOUT=20, `pll_locked` held 0 → `pll_rst` re-pulses every 24 cycles. Without the macro → a single pulse only.
- `rst_n` low during RELEASE after domain 1 is released → next edge: all reset values restored and `relock_count`=0.
